// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer
//   Command sequencer between the UART receiver, the combinational ALU and
//   the UART transmitter. It collects operand A, operand B and an opcode
//   byte in order, holds them on registered ALU inputs, captures the ALU
//   result one cycle later and issues a single transmit request for it.
//   Unknown opcodes transmit ERR_CODE instead of the result. Bytes that
//   arrive while a command is in flight are dropped and flagged.
//
//   Optional feature macro: RX_TIMEOUT_EN
//     defined   : a 16-bit baud-tick counter aborts a partial command
//                 (back to GET_A, one-cycle o_timeout pulse) when no byte
//                 arrives within TIMEOUT_TICKS ticks in GET_B / GET_OP.
//     undefined : no counter, i_s_tick unused, o_timeout tied to 0.
//
// Ports
//   i_clock         system clock, rising edge
//   i_reset         asynchronous active-low reset
//   i_rx_done_tick  receiver byte-valid pulse, i_rx_data valid with it
//   i_rx_data       received byte
//   i_s_tick        16x baud tick (timeout counting only)
//   i_alu_result    combinational ALU output
//   i_tx_done_tick  transmitter frame-finished pulse
//   o_alu_a/b/op    registered ALU operands and opcode
//   o_tx_start      one-cycle transmit request
//   o_tx_data       byte to transmit, stable until the frame completes
//   o_busy          high in EXEC, SEND and WAIT_TX
//   o_overrun       sticky dropped-byte flag
//   o_timeout       one-cycle inter-byte timeout pulse
module uart_alu_sequencer #(
    parameter int                N_BITS        = 8,
    parameter int                N_OP          = 6,
    parameter logic [N_BITS-1:0] ERR_CODE      = 8'hFF,
    parameter logic [15:0]       TIMEOUT_TICKS = 16'd40000
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_rx_done_tick,
    input  logic [N_BITS-1:0] i_rx_data,
    input  logic              i_s_tick,
    input  logic [N_BITS-1:0] i_alu_result,
    input  logic              i_tx_done_tick,
    output logic [N_BITS-1:0] o_alu_a,
    output logic [N_BITS-1:0] o_alu_b,
    output logic [N_OP-1:0]   o_alu_op,
    output logic              o_tx_start,
    output logic [N_BITS-1:0] o_tx_data,
    output logic              o_busy,
    output logic              o_overrun,
    output logic              o_timeout
);

    typedef enum logic [5:0] {
        GET_A   = 6'b000001,
        GET_B   = 6'b000010,
        GET_OP  = 6'b000100,
        EXEC    = 6'b001000,
        SEND    = 6'b010000,
        WAIT_TX = 6'b100000
    } state_t;

    state_t state, state_n;
    logic   op_valid;
    logic   tmo_fire;

    function automatic logic op_is_valid(input logic [N_OP-1:0] op);
        case (op)
            6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100110, 6'b100111, 6'b000011, 6'b000010: op_is_valid = 1'b1;
            default:                                    op_is_valid = 1'b0;
        endcase
    endfunction

    // ---------------------------------------------------------------
    // Inter-byte timeout
    // ---------------------------------------------------------------
`ifdef RX_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        tmo_q;
    logic        in_get_bop;

    assign in_get_bop = (state == GET_B) || (state == GET_OP);
    // A byte landing on the expiring tick wins: the command carries on.
    assign tmo_fire   = in_get_bop && i_s_tick && !i_rx_done_tick &&
                        (tmo_cnt == TIMEOUT_TICKS - 16'd1);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            tmo_cnt <= '0;
            tmo_q   <= 1'b0;
        end else begin
            tmo_q <= tmo_fire;
            if (i_rx_done_tick || tmo_fire || (state_n == GET_A && state != GET_A))
                tmo_cnt <= '0;
            else if (in_get_bop && i_s_tick)
                tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign o_timeout = tmo_q;
`else
    logic unused_tmo;
    assign unused_tmo = i_s_tick ^ (^TIMEOUT_TICKS);
    assign tmo_fire   = 1'b0;
    assign o_timeout  = 1'b0;
`endif

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) state <= GET_A;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            GET_A:   if (i_rx_done_tick) state_n = GET_B;
            GET_B:   if (i_rx_done_tick) state_n = GET_OP;
                     else if (tmo_fire)  state_n = GET_A;
            GET_OP:  if (i_rx_done_tick) state_n = EXEC;
                     else if (tmo_fire)  state_n = GET_A;
            EXEC:    state_n = SEND;
            SEND:    state_n = WAIT_TX;
            WAIT_TX: if (i_tx_done_tick) state_n = GET_A;
            default: state_n = GET_A;
        endcase
    end

    assign o_tx_start = (state == SEND);
    assign o_busy     = (state == EXEC) || (state == SEND) || (state == WAIT_TX);

    // ---------------------------------------------------------------
    // Operand / result registers
    // ---------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_alu_a   <= '0;
            o_alu_b   <= '0;
            o_alu_op  <= '0;
            op_valid  <= 1'b0;
            o_tx_data <= '0;
            o_overrun <= 1'b0;
        end else begin
            if (i_rx_done_tick) begin
                case (state)
                    GET_A:  o_alu_a <= i_rx_data;
                    GET_B:  o_alu_b <= i_rx_data;
                    GET_OP: begin
                        // An invalid opcode leaves the ALU opcode untouched.
                        if (op_is_valid(i_rx_data[N_OP-1:0])) begin
                            o_alu_op <= i_rx_data[N_OP-1:0];
                            op_valid <= 1'b1;
                        end else begin
                            op_valid <= 1'b0;
                        end
                    end
                    default: o_overrun <= 1'b1;
                endcase
            end
            // ALU inputs have been stable for a full cycle by now.
            if (state == EXEC)
                o_tx_data <= op_valid ? i_alu_result : ERR_CODE;
        end
    end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
module tb_uart_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_tick, s_tick, tx_done;
    logic [7:0] rx_data, alu_res;
    logic [7:0] alu_a, alu_b, tx_data;
    logic [5:0] alu_op;
    logic       tx_start, busy, overrun, timeout;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    int         cyc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_alu_sequencer #(.TIMEOUT_TICKS(16'd20)) dut (
        .i_clock(clk), .i_reset(rst_n), .i_rx_done_tick(rx_tick),
        .i_rx_data(rx_data), .i_s_tick(s_tick), .i_alu_result(alu_res),
        .i_tx_done_tick(tx_done), .o_alu_a(alu_a), .o_alu_b(alu_b),
        .o_alu_op(alu_op), .o_tx_start(tx_start), .o_tx_data(tx_data),
        .o_busy(busy), .o_overrun(overrun), .o_timeout(timeout)
    );

    // Behavioural Basys3 ALU
    always_comb begin
        alu_res = 8'h00;
        case (alu_op)
            6'b100000: alu_res = alu_a + alu_b;
            6'b100010: alu_res = alu_a - alu_b;
            6'b100100: alu_res = alu_a & alu_b;
            6'b100101: alu_res = alu_a | alu_b;
            6'b100110: alu_res = alu_a ^ alu_b;
            6'b100111: alu_res = ~(alu_a | alu_b);
            6'b000011: alu_res = $unsigned($signed(alu_a) >>> alu_b);
            6'b000010: alu_res = alu_a >> alu_b;
            default:   alu_res = 8'h00;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor: every transmit request must match the next queued
    // byte and appear in the SEND cycle, one edge after the EXEC edge.
    always @(negedge clk) begin
        if (rst_n && tx_start) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_tx_start", {24'h0, tx_data}, 32'hDEAD);
            end else begin
                chk("tx_data", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
                chk("tx_latency", cyc, cyc_q.pop_front());
            end
        end
    end

    // All drives happen #1 after a rising edge; tasks return likewise.
    task automatic send_byte(input logic [7:0] d);
        rx_data = d; rx_tick = 1'b1;
        @(posedge clk); #1;
        rx_tick = 1'b0;
    endtask

    // Opcode byte sampled at edge E -> EXEC after E, SEND after E+1.
    task automatic send_cmd(input logic [7:0] a, b, op, input logic [7:0] exp);
        send_byte(a); send_byte(b);
        exp_q.push_back(exp);
        send_byte(op);
        cyc_q.push_back(cyc + 1);
    endtask

    // Bounded wait for the transmit request; leaves the DUT in WAIT_TX.
    task automatic wait_send;
        logic seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); seen = tx_start;
        end
        chk("tx_start_seen", {31'h0, seen}, 32'h1);
        @(posedge clk); #1;
    endtask

    task automatic tx_finish;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rx_tick = 1'b0; s_tick = 1'b0; tx_done = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_alu_a", alu_a, 0);    chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);  chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0); chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0); chk("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: ADD 5 + 3
        send_cmd(8'h05, 8'h03, 8'h20, 8'h08);
        chk("t1_alu_a", alu_a, 8'h05); chk("t1_alu_b", alu_b, 8'h03);
        chk("t1_alu_op", alu_op, 6'b100000);
        chk("t1_busy", busy, 1);
        wait_send();
        tx_finish();

        // 2: invalid opcode -> error byte, opcode register unchanged
        send_cmd(8'hF0, 8'h0F, 8'h3F, 8'hFF);
        chk("t2_alu_op", alu_op, 6'b100000);
        wait_send();
        tx_finish();

        // 3: byte during WAIT_TX is dropped, overrun sticks
        send_cmd(8'h01, 8'h01, 8'h22, 8'h00);
        chk("t3_alu_a_pre", alu_a, 8'h01);
        wait_send();
        send_byte(8'hAA);
        chk("t3_overrun", overrun, 1);
        chk("t3_alu_a_kept", alu_a, 8'h01);
        tx_finish();
        repeat (3) @(posedge clk);
        #1;
        chk("t3_overrun_sticky", overrun, 1);
        chk("t3_idle", busy, 0);

        // 4: reset while in GET_OP
        send_byte(8'h0C); send_byte(8'h0A);
        rst_n = 1'b0;
        #1;
        chk("t4_alu_a", alu_a, 0); chk("t4_alu_b", alu_b, 0);
        chk("t4_alu_op", alu_op, 0); chk("t4_tx_data", tx_data, 0);
        chk("t4_overrun", overrun, 0); chk("t4_tx_start", tx_start, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_idle_after", busy, 0);
        send_cmd(8'h0C, 8'h0A, 8'h25, 8'h0E);
        wait_send();
        tx_finish();

        // 5: inter-byte timeout
`ifdef RX_TIMEOUT_EN
        send_byte(8'h07);
        for (int i = 0; i < 19; i++) begin
            s_tick = 1'b1; @(posedge clk); #1; s_tick = 1'b0;
        end
        chk("t5_no_early_timeout", timeout, 0);
        s_tick = 1'b1; @(posedge clk); #1; s_tick = 1'b0;
        chk("t5_timeout_pulse", timeout, 1);
        chk("t5_alu_a_kept", alu_a, 8'h07);
        @(posedge clk); #1;
        chk("t5_timeout_one_cycle", timeout, 0);
`else
        for (int i = 0; i < 25; i++) begin
            s_tick = 1'b1; @(posedge clk); #1; s_tick = 1'b0;
        end
        chk("t5_timeout_absent", timeout, 0);
`endif
        send_cmd(8'h02, 8'h02, 8'h24, 8'h02);
        chk("t5_alu_a", alu_a, 8'h02); chk("t5_alu_b", alu_b, 8'h02);
        wait_send();
        tx_finish();

        // 6: rx and tx_done coincide in WAIT_TX
        send_cmd(8'h10, 8'h01, 8'h02, 8'h08);
        wait_send();
        chk("t6_overrun_pre", overrun, 0);
        rx_data = 8'h55; rx_tick = 1'b1; tx_done = 1'b1;
        @(posedge clk); #1;
        rx_tick = 1'b0; tx_done = 1'b0;
        chk("t6_idle", busy, 0);
        chk("t6_overrun", overrun, 1);
        chk("t6_alu_a_kept", alu_a, 8'h10);
        send_cmd(8'h03, 8'h04, 8'h26, 8'h07);
        chk("t6_next_alu_a", alu_a, 8'h03);
        wait_send();
        tx_finish();

        repeat (5) @(posedge clk);
        #1;
        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
